// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg
//   Shared definitions for the reset sequencer: FSM state encoding, the
//   width of the completed-sequence counter and a small constant helper.
//   Imported by reset_sequencer (and usable by any block that decodes its
//   state for debug).
package reset_sequencer_pkg;

  localparam int SEQ_COUNT_W = 8;
  localparam logic [SEQ_COUNT_W-1:0] SEQ_COUNT_MAX = '1;

  // HOLD: every stage in reset, waiting out the hold time.
  // RELEASE: stages leaving reset one by one, GAP cycles apart.
  // RUN: everything out of reset, sequence complete.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// reset_debounce
//   Conditions a raw asynchronous push button for use as a restart request:
//   two-flop synchroniser, then a stability counter that only accepts a new
//   level once it has been seen for DEBOUNCE_CYCLES consecutive cycles, then
//   a one-cycle pulse on each accepted rising edge.
//   Only compiled when RESET_SEQUENCER_BUTTON_EN is defined.
// Ports
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   raw      in  asynchronous active-high button
//   clean    out debounced level
//   rise     out one-cycle pulse when clean goes 0 -> 1
`ifdef RESET_SEQUENCER_BUTTON_EN
module reset_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg, sync2_reg;
  logic             clean_reg, clean_next;
  logic             rise_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // The counter only runs while the synchronised level disagrees with the
  // accepted one; any agreement (a glitch ending) starts the count over.
  always_comb begin
    clean_next = clean_reg;
    cnt_next   = '0;
    if (sync2_reg != clean_reg) begin
      if (cnt_reg == CNT_LAST) begin
        clean_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      clean_reg <= 1'b0;
      cnt_reg   <= '0;
      rise_reg  <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      clean_reg <= clean_next;
      cnt_reg   <= cnt_next;
      rise_reg  <= clean_next & ~clean_reg;
    end
  end

  assign clean = clean_reg;
  assign rise  = rise_reg;

endmodule
`endif

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Takes the power-on reset (active-low reset_n) and releases STAGES
//   active-high stage resets in index order: all held for HOLD_CYCLES, then
//   one stage every GAP_CYCLES. A soft_req pulse (or, when the macro
//   RESET_SEQUENCER_BUTTON_EN is defined, a debounced button press) restarts
//   the whole sequence. All outputs are registered.
// Ports
//   clk          in   system clock
//   reset_n      in   synchronous active-low reset
//   soft_req     in   one-cycle restart request
//   button       in   raw push button (used only with RESET_SEQUENCER_BUTTON_EN)
//   stage_reset  out  per-stage active-high reset, released 0..STAGES-1
//   all_ready    out  every stage out of reset
//   busy         out  sequence holding or releasing
//   seq_count    out  completed sequences since reset_n, saturating
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STAGES          = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int GAP_CYCLES      = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   soft_req,
  input  logic                   button,
  output logic [STAGES-1:0]      stage_reset,
  output logic                   all_ready,
  output logic                   busy,
  output logic [SEQ_COUNT_W-1:0] seq_count
);

  localparam int CNT_W = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int IDX_W = $clog2(STAGES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(STAGES);

  seq_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;       // next stage to release
  logic [STAGES-1:0]      stage_reset_reg, stage_reset_next;
  logic                   all_ready_reg, all_ready_next;
  logic                   busy_reg, busy_next;
  logic [SEQ_COUNT_W-1:0] seq_count_reg, seq_count_next;

  logic                   restart_req;
  logic                   cnt_done;
  logic                   release_now;
  logic [STAGES-1:0]      release_mask;

`ifdef RESET_SEQUENCER_BUTTON_EN
  logic button_rise;
  logic unused_button_clean;

  reset_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (button),
    .clean   (unused_button_clean),
    .rise    (button_rise)
  );

  assign restart_req = soft_req | button_rise;
`else
  logic unused_button;
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign unused_button = button;
  assign restart_req   = soft_req;
`endif

  assign cnt_done    = (state_reg == ST_HOLD) ? (cnt_reg == HOLD_LAST)
                                              : (cnt_reg == GAP_LAST);
  assign release_now = (state_reg != ST_RUN) && (idx_reg != IDX_DONE) &&
                       cnt_done && !restart_req;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_release
      assign release_mask[gi] = release_now && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // The counter holds the number of edges elapsed in the current phase.
  // A restart edge is itself the first hold edge (exactly like the first
  // edge after reset_n rises, where the counter steps 0 -> 1), so a restart
  // loads 1 and both paths release stage 0 HOLD_CYCLES edges later.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    idx_next         = idx_reg;
    stage_reset_next = stage_reset_reg & ~release_mask;
    all_ready_next   = all_ready_reg;
    busy_next        = busy_reg;
    seq_count_next   = seq_count_reg;

    if (restart_req || (state_reg != ST_HOLD && state_reg != ST_RELEASE &&
                        state_reg != ST_RUN)) begin
      state_next       = ST_HOLD;
      cnt_next         = CNT_W'(1);
      idx_next         = '0;
      stage_reset_next = '1;
      all_ready_next   = 1'b0;
      busy_next        = 1'b1;
    end else if (state_reg != ST_RUN) begin
      if (idx_reg == IDX_DONE) begin
        // Last stage cleared on the previous edge.
        state_next     = ST_RUN;
        all_ready_next = 1'b1;
        busy_next      = 1'b0;
        if (seq_count_reg != SEQ_COUNT_MAX) begin
          seq_count_next = seq_count_reg + 1'b1;
        end
      end else if (cnt_done) begin
        state_next = ST_RELEASE;
        cnt_next   = CNT_W'(1);
        idx_next   = idx_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= ST_HOLD;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      stage_reset_reg <= '1;
      all_ready_reg   <= 1'b0;
      busy_reg        <= 1'b1;
      seq_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      stage_reset_reg <= stage_reset_next;
      all_ready_reg   <= all_ready_next;
      busy_reg        <= busy_next;
      seq_count_reg   <= seq_count_next;
    end
  end

  assign stage_reset = stage_reset_reg;
  assign all_ready   = all_ready_reg;
  assign busy        = busy_reg;
  assign seq_count   = seq_count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Drives reset_sequencer (STAGES=3, HOLD=4, GAP=2, DEBOUNCE=5) with directed
//   and random reset_n / soft_req / button stimulus. A timeline model (edges
//   since the last sequence start) gives the expected outputs every cycle;
//   directed literal checks pin the model. Define RESET_SEQUENCER_BUTTON_EN
//   to exercise the button path.
module tb_reset_sequencer;

  localparam int S = 3;
  localparam int H = 4;
  localparam int G = 2;
  localparam int D = 5;
  localparam int DONE_K = H + (S - 1) * G + 1;  // edges from start to all_ready

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         soft_req = 1'b0;
  logic         button = 1'b0;
  logic [S-1:0] stage_reset;
  logic         all_ready;
  logic         busy;
  logic [7:0]   seq_count;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Model: m_k = edges since the sequence start edge (capped at DONE_K).
  bit m_inrst = 1'b1;
  int m_k = 0;
  int m_seq = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .STAGES(S), .HOLD_CYCLES(H), .GAP_CYCLES(G), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .soft_req(soft_req), .button(button),
    .stage_reset(stage_reset), .all_ready(all_ready), .busy(busy),
    .seq_count(seq_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      m_inrst = 1'b1;
      m_k = 0;
      m_seq = 0;
    end else if (m_inrst || soft_req) begin
      m_inrst = 1'b0;
      m_k = 0;
    end else if (m_k < DONE_K) begin
      m_k++;
      if (m_k == DONE_K && m_seq < 255) m_seq++;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [S-1:0] e_stage;
      logic         e_ready;
      for (int i = 0; i < S; i++) e_stage[i] = m_inrst || (m_k < H + i * G);
      e_ready = !m_inrst && (m_k >= DONE_K);
      check("stage_reset", 32'(stage_reset), 32'(e_stage));
      check("all_ready", 32'(all_ready), 32'(e_ready));
      check("busy", 32'(busy), 32'(!e_ready));
      check("seq_count", 32'(seq_count), 32'(m_seq));
    end
  end

  task automatic step(input logic rn, input logic sr, input logic bt);
    reset_n = rn;
    soft_req = sr;
    button = bt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_rises;
    logic prev_busy;

    // Power-on: reset_n low 3 cycles, then E0.
    repeat (3) step(0, 0, 0);
    check_en = 1'b1;
    check("rst_stage", 32'(stage_reset), 32'h7);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_seq", 32'(seq_count), 32'h0);
    step(1, 0, 0);                       // E0
    check("e0_stage", 32'(stage_reset), 32'h7);
    repeat (3) step(1, 0, 0);            // E0+3
    check("e0p3_stage", 32'(stage_reset), 32'h7);
    step(1, 0, 0);                       // E0+4
    check("e0p4_stage", 32'(stage_reset), 32'h6);
    repeat (2) step(1, 0, 0);            // E0+6
    check("e0p6_stage", 32'(stage_reset), 32'h4);
    repeat (2) step(1, 0, 0);            // E0+8
    check("e0p8_stage", 32'(stage_reset), 32'h0);
    check("e0p8_ready", 32'(all_ready), 32'h0);
    step(1, 0, 0);                       // E0+9
    check("e0p9_ready", 32'(all_ready), 32'h1);
    check("e0p9_busy", 32'(busy), 32'h0);
    check("e0p9_seq", 32'(seq_count), 32'h1);
    repeat (3) step(1, 0, 0);

    // Soft restart from RUN at edge T.
    step(1, 1, 0);
    check("t_stage", 32'(stage_reset), 32'h7);
    check("t_busy", 32'(busy), 32'h1);
    check("t_seq", 32'(seq_count), 32'h1);
    repeat (4) step(1, 0, 0);
    check("tp4_stage", 32'(stage_reset), 32'h6);
    repeat (4) step(1, 0, 0);
    check("tp8_stage", 32'(stage_reset), 32'h0);
    step(1, 0, 0);
    check("tp9_seq", 32'(seq_count), 32'h2);

    // Restart in the middle of RELEASE (stage 0 already out).
    step(1, 1, 0);
    repeat (4) step(1, 0, 0);
    check("mid_stage_before", 32'(stage_reset), 32'h6);
    step(1, 1, 0);
    check("mid_stage_after", 32'(stage_reset), 32'h7);
    check("mid_seq", 32'(seq_count), 32'h2);
    repeat (8) step(1, 0, 0);
    check("mid_p8_ready", 32'(all_ready), 32'h0);
    step(1, 0, 0);
    check("mid_p9_seq", 32'(seq_count), 32'h3);

    // reset_n mid-sequence aborts.
    step(1, 1, 0);
    repeat (6) step(1, 0, 0);
    step(0, 0, 0);
    check("abort_stage", 32'(stage_reset), 32'h7);
    check("abort_ready", 32'(all_ready), 32'h0);
    check("abort_seq", 32'(seq_count), 32'h0);
    step(1, 0, 0);
    repeat (9) step(1, 0, 0);
    check("rerun_seq", 32'(seq_count), 32'h1);

    // soft_req together with reset_n low: reset wins.
    step(0, 1, 0);
    check("both_stage", 32'(stage_reset), 32'h7);
    check("both_seq", 32'(seq_count), 32'h0);
    step(1, 0, 0);
    repeat (9) step(1, 0, 0);

`ifdef RESET_SEQUENCER_BUTTON_EN
    // Button debounce: short glitches ignored, a long press restarts once.
    check_en = 1'b0;
    busy_rises = 0;
    prev_busy = busy;
    for (int r = 0; r < 3; r++) begin
      repeat (D - 1 - r) begin
        step(1, 0, 1);
        if (busy && !prev_busy) busy_rises++;
        prev_busy = busy;
      end
      repeat (10) begin
        step(1, 0, 0);
        if (busy && !prev_busy) busy_rises++;
        prev_busy = busy;
      end
    end
    check("glitch_restarts", 32'(busy_rises), 32'h0);
    busy_rises = 0;
    repeat (20) begin
      step(1, 0, 1);
      if (busy && !prev_busy) busy_rises++;
      prev_busy = busy;
    end
    repeat (40) begin
      step(1, 0, 0);
      if (busy && !prev_busy) busy_rises++;
      prev_busy = busy;
    end
    check("press_restarts", 32'(busy_rises), 32'h1);
    check("press_seq", 32'(seq_count), 32'h2);
    step(0, 0, 0);
    check_en = 1'b1;
`else
    // Without the button feature, button activity changes nothing.
    busy_rises = 0;
    prev_busy = busy;
    repeat (40) begin
      step(1, 0, 1'($urandom_range(0, 1)));
      if (busy && !prev_busy) busy_rises++;
      prev_busy = busy;
    end
    check("button_ignored_rises", 32'(busy_rises), 32'h0);
    check("button_ignored_seq", 32'(seq_count), 32'h1);
`endif

    // Random reset_n / soft_req / button traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic rn, sr, bt;
      rn = ($urandom_range(0, 99) >= 2);
      sr = ($urandom_range(0, 99) < 4);
`ifdef RESET_SEQUENCER_BUTTON_EN
      bt = 1'b0;
`else
      bt = 1'($urandom_range(0, 1));
`endif
      step(rn, sr, bt);
    end

    // Saturation of seq_count at 255.
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (9) step(1, 0, 0);
    for (int n = 0; n < 260; n++) begin
      step(1, 1, 0);
      repeat (9) step(1, 0, 0);
    end
    check("sat_seq", 32'(seq_count), 32'hFF);
    check("sat_ready", 32'(all_ready), 32'h1);

    step(1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
